// File: rtl/sar_result_averager_if.sv
// Result port of the SAR averager: valid/ready handshake carrying the block average, minimum and maximum.
interface sar_result_averager_if #(
  parameter int CODE_W = 8
);
  logic              avg_valid;
  logic              avg_ready;
  logic [CODE_W-1:0] avg_data;
  logic [CODE_W-1:0] avg_min;
  logic [CODE_W-1:0] avg_max;

  modport master (
    output avg_valid,
    output avg_data,
    output avg_min,
    output avg_max,
    input  avg_ready
  );

  modport slave (
    input  avg_valid,
    input  avg_data,
    input  avg_min,
    input  avg_max,
    output avg_ready
  );
endinterface

// File: rtl/sar_result_averager.sv
// Captures SAR codes on done rising edges, restarts the SAR, and averages blocks of 2^log2_n codes
// into a holding register with min/max and a sticky overrun flag.
module sar_result_averager #(
  parameter int CODE_W   = 8,
  parameter int MAX_LOG2 = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_ena,
  input  logic                i_sar_done,
  input  logic [CODE_W-1:0]   i_sar_code,
  input  logic [2:0]          i_log2_n,
  output logic                o_sar_restart,
  output logic                o_overrun,
  input  logic                i_clr_overrun,
  output logic [MAX_LOG2-1:0] o_sample_cnt,
  sar_result_averager_if.master avg_if
);

  localparam int SUM_W = CODE_W + MAX_LOG2;

  logic                r_done_q;
  logic                r_sar_restart;
  logic [SUM_W-1:0]    r_sum;
  logic [MAX_LOG2-1:0] r_sample_cnt;
  logic [CODE_W-1:0]   r_min;
  logic [CODE_W-1:0]   r_max;
  logic [2:0]          r_log2;
  logic                r_avg_valid;
  logic [CODE_W-1:0]   r_avg_data;
  logic [CODE_W-1:0]   r_avg_min;
  logic [CODE_W-1:0]   r_avg_max;
  logic                r_overrun;

  logic                w_event;
  logic [2:0]          w_log2;
  logic [SUM_W-1:0]    w_sum_next;
  logic [CODE_W-1:0]   w_min_next;
  logic [CODE_W-1:0]   w_max_next;
  logic [MAX_LOG2:0]   w_cnt_inc;
  logic [MAX_LOG2:0]   w_block_size;
  logic                w_block_end;

  assign w_event      = i_ena && i_sar_done && !r_done_q;
  // The block size is taken from the live input only on the first sample of a block.
  assign w_log2       = (r_sample_cnt == '0) ? i_log2_n : r_log2;
  assign w_sum_next   = r_sum + SUM_W'(i_sar_code);
  assign w_min_next   = (i_sar_code < r_min) ? i_sar_code : r_min;
  assign w_max_next   = (i_sar_code > r_max) ? i_sar_code : r_max;
  assign w_cnt_inc    = {1'b0, r_sample_cnt} + 1'b1;
  assign w_block_size = (MAX_LOG2+1)'(1) << w_log2;
  assign w_block_end  = w_event && (w_cnt_inc == w_block_size);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_q      <= 1'b0;
      r_sar_restart <= 1'b0;
      r_sum         <= '0;
      r_sample_cnt  <= '0;
      r_min         <= '1;
      r_max         <= '0;
      r_log2        <= '0;
    end else begin
      r_done_q      <= i_sar_done;
      r_sar_restart <= w_event;
      if (w_event) begin
        r_log2 <= w_log2;
        if (w_block_end) begin
          r_sum        <= '0;
          r_sample_cnt <= '0;
          r_min        <= '1;
          r_max        <= '0;
        end else begin
          r_sum        <= w_sum_next;
          r_sample_cnt <= w_cnt_inc[MAX_LOG2-1:0];
          r_min        <= w_min_next;
          r_max        <= w_max_next;
        end
      end
    end
  end

  // A completing block always reloads the holding register; overrun marks a result lost unread.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_avg_valid <= 1'b0;
      r_avg_data  <= '0;
      r_avg_min   <= '0;
      r_avg_max   <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_block_end) begin
        r_avg_valid <= 1'b1;
        r_avg_data  <= CODE_W'(w_sum_next >> w_log2);
        r_avg_min   <= w_min_next;
        r_avg_max   <= w_max_next;
      end else if (r_avg_valid && avg_if.avg_ready) begin
        r_avg_valid <= 1'b0;
      end

      if (w_block_end && r_avg_valid && !avg_if.avg_ready) begin
        r_overrun <= 1'b1;
      end else if (i_clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_sar_restart    = r_sar_restart;
  assign o_overrun        = r_overrun;
  assign o_sample_cnt     = r_sample_cnt;
  assign avg_if.avg_valid = r_avg_valid;
  assign avg_if.avg_data  = r_avg_data;
  assign avg_if.avg_min   = r_avg_min;
  assign avg_if.avg_max   = r_avg_max;

endmodule

// File: tb/tb_sar_result_averager.sv
// Randomised and directed bench for sar_result_averager, checked every cycle against a
// block-level model that keeps the current block's codes in a queue.
module tb_sar_result_averager;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       i_ena;
  logic       i_sar_done;
  logic [7:0] i_sar_code;
  logic [2:0] i_log2_n;
  logic       o_sar_restart;
  logic       o_overrun;
  logic       i_clr_overrun;
  logic [6:0] o_sample_cnt;

  sar_result_averager_if #(.CODE_W(8)) avg_if ();

  sar_result_averager #(.CODE_W(8), .MAX_LOG2(7)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_ena         (i_ena),
    .i_sar_done    (i_sar_done),
    .i_sar_code    (i_sar_code),
    .i_log2_n      (i_log2_n),
    .o_sar_restart (o_sar_restart),
    .o_overrun     (o_overrun),
    .i_clr_overrun (i_clr_overrun),
    .o_sample_cnt  (o_sample_cnt),
    .avg_if        (avg_if.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: outputs derived from the list of codes collected so far in the block.
  int   mBlock[$];
  int   mLog2 = 0;
  logic mDoneQ = 1'b0;
  logic mRestart = 1'b0;
  logic mValid = 1'b0;
  logic mOverrun = 1'b0;
  int   mData = 0, mMin = 0, mMax = 0;
  logic mEv, mNextValid, mNextOv;
  int   mSum, mLo, mHi;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mBlock.delete();
      mLog2 = 0; mDoneQ = 0; mRestart = 0; mValid = 0; mOverrun = 0;
      mData = 0; mMin = 0; mMax = 0;
    end else begin
      mEv        = i_ena && i_sar_done && !mDoneQ;
      mNextValid = mValid && !avg_if.avg_ready;
      mNextOv    = i_clr_overrun ? 1'b0 : mOverrun;
      if (mEv) begin
        if (mBlock.size() == 0) mLog2 = int'(i_log2_n);
        mBlock.push_back(int'(i_sar_code));
        if (mBlock.size() == (1 << mLog2)) begin
          mSum = 0; mLo = 255; mHi = 0;
          foreach (mBlock[k]) begin
            mSum += mBlock[k];
            if (mBlock[k] < mLo) mLo = mBlock[k];
            if (mBlock[k] > mHi) mHi = mBlock[k];
          end
          mData = mSum / (1 << mLog2);
          mMin = mLo;
          mMax = mHi;
          if (mValid && !avg_if.avg_ready) mNextOv = 1'b1;
          mNextValid = 1'b1;
          mBlock.delete();
        end
      end
      mRestart = mEv;
      mValid   = mNextValid;
      mOverrun = mNextOv;
      mDoneQ   = i_sar_done;
    end
  end

  always @(negedge clk) begin
    if ($time > 2) begin
      checkOutput("model restart", 32'(o_sar_restart), 32'(mRestart));
      checkOutput("model valid", 32'(avg_if.avg_valid), 32'(mValid));
      checkOutput("model data", 32'(avg_if.avg_data), 32'(mData));
      checkOutput("model min", 32'(avg_if.avg_min), 32'(mMin));
      checkOutput("model max", 32'(avg_if.avg_max), 32'(mMax));
      checkOutput("model overrun", 32'(o_overrun), 32'(mOverrun));
      checkOutput("model sample_cnt", 32'(o_sample_cnt), 32'(mBlock.size()));
    end
  end

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] code, input int hold);
    i_sar_done = 1'b1;
    i_sar_code = code;
    repeat (hold) stepClk();
    i_sar_done = 1'b0;
    stepClk();
  endtask

  int restartCount;

  initial begin
    i_ena = 1'b1; i_sar_done = 1'b0; i_sar_code = '0; i_log2_n = '0;
    i_clr_overrun = 1'b0; avg_if.avg_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    stepClk();

    // Single-sample block
    i_log2_n = 3'd0;
    i_sar_done = 1'b1; i_sar_code = 8'h5A;
    stepClk();
    checkOutput("t1 restart", 32'(o_sar_restart), 32'd1);
    checkOutput("t1 valid", 32'(avg_if.avg_valid), 32'd1);
    checkOutput("t1 data", 32'(avg_if.avg_data), 32'h5A);
    checkOutput("t1 min", 32'(avg_if.avg_min), 32'h5A);
    checkOutput("t1 max", 32'(avg_if.avg_max), 32'h5A);
    i_sar_done = 1'b0;
    stepClk();
    checkOutput("t1 restart low", 32'(o_sar_restart), 32'd0);
    avg_if.avg_ready = 1'b1;
    stepClk();
    checkOutput("t1 accepted", 32'(avg_if.avg_valid), 32'd0);

    // Four-sample block
    i_log2_n = 3'd2;
    applyStimulus(8'd10, 1);
    checkOutput("t2 cnt1", 32'(o_sample_cnt), 32'd1);
    applyStimulus(8'd20, 1);
    checkOutput("t2 cnt2", 32'(o_sample_cnt), 32'd2);
    applyStimulus(8'd30, 1);
    checkOutput("t2 cnt3", 32'(o_sample_cnt), 32'd3);
    i_sar_done = 1'b1; i_sar_code = 8'd41;
    stepClk();
    checkOutput("t2 valid", 32'(avg_if.avg_valid), 32'd1);
    checkOutput("t2 data", 32'(avg_if.avg_data), 32'h19);
    checkOutput("t2 min", 32'(avg_if.avg_min), 32'h0A);
    checkOutput("t2 max", 32'(avg_if.avg_max), 32'h29);
    checkOutput("t2 overrun", 32'(o_overrun), 32'd0);
    checkOutput("t2 cnt0", 32'(o_sample_cnt), 32'd0);
    i_sar_done = 1'b0;
    stepClk();

    // 128 full-scale samples
    avg_if.avg_ready = 1'b0;
    i_log2_n = 3'd7;
    for (int k = 0; k < 127; k++) applyStimulus(8'hFF, 1);
    checkOutput("t3 cnt127", 32'(o_sample_cnt), 32'd127);
    i_sar_done = 1'b1;
    stepClk();
    checkOutput("t3 data", 32'(avg_if.avg_data), 32'hFF);
    checkOutput("t3 min", 32'(avg_if.avg_min), 32'hFF);
    checkOutput("t3 max", 32'(avg_if.avg_max), 32'hFF);
    i_sar_done = 1'b0;
    avg_if.avg_ready = 1'b1;
    stepClk();

    // Overrun and its clear
    avg_if.avg_ready = 1'b0;
    i_log2_n = 3'd0;
    applyStimulus(8'h11, 1);
    i_sar_done = 1'b1; i_sar_code = 8'h22;
    stepClk();
    checkOutput("t4 data", 32'(avg_if.avg_data), 32'h22);
    checkOutput("t4 overrun set", 32'(o_overrun), 32'd1);
    i_sar_done = 1'b0;
    stepClk();
    i_clr_overrun = 1'b1;
    stepClk();
    i_clr_overrun = 1'b0;
    checkOutput("t4 overrun clr", 32'(o_overrun), 32'd0);
    avg_if.avg_ready = 1'b1;
    i_sar_done = 1'b1; i_sar_code = 8'h33;
    stepClk();
    checkOutput("t4 valid kept", 32'(avg_if.avg_valid), 32'd1);
    checkOutput("t4 data33", 32'(avg_if.avg_data), 32'h33);
    checkOutput("t4 no overrun", 32'(o_overrun), 32'd0);
    i_sar_done = 1'b0;
    stepClk();
    checkOutput("t4 drained", 32'(avg_if.avg_valid), 32'd0);

    // Long done level, then a done that rises while disabled
    restartCount = 0;
    i_sar_done = 1'b1; i_sar_code = 8'h80;
    for (int k = 0; k < 10; k++) begin
      stepClk();
      restartCount += int'(o_sar_restart);
    end
    i_sar_done = 1'b0;
    stepClk();
    restartCount += int'(o_sar_restart);
    checkOutput("t5 one restart", 32'(restartCount), 32'd1);
    checkOutput("t5 data", 32'(avg_if.avg_data), 32'h80);
    restartCount = 0;
    i_ena = 1'b0; i_sar_done = 1'b1; i_sar_code = 8'h33;
    repeat (3) begin stepClk(); restartCount += int'(o_sar_restart); end
    i_ena = 1'b1;
    repeat (3) begin stepClk(); restartCount += int'(o_sar_restart); end
    i_sar_done = 1'b0;
    stepClk();
    checkOutput("t5 no restart", 32'(restartCount), 32'd0);
    checkOutput("t5 data held", 32'(avg_if.avg_data), 32'h80);

    // Reset mid-block and block size latched at block start
    i_log2_n = 3'd2;
    applyStimulus(8'h40, 1);
    applyStimulus(8'h40, 1);
    checkOutput("t6 cnt2", 32'(o_sample_cnt), 32'd2);
    rst_n = 1'b0;
    stepClk();
    checkOutput("t6 rst valid", 32'(avg_if.avg_valid), 32'd0);
    checkOutput("t6 rst data", 32'(avg_if.avg_data), 32'd0);
    checkOutput("t6 rst min", 32'(avg_if.avg_min), 32'd0);
    checkOutput("t6 rst max", 32'(avg_if.avg_max), 32'd0);
    checkOutput("t6 rst cnt", 32'(o_sample_cnt), 32'd0);
    rst_n = 1'b1;
    stepClk();
    applyStimulus(8'h40, 1);
    i_log2_n = 3'd0;
    applyStimulus(8'h40, 1);
    checkOutput("t6 size latched", 32'(o_sample_cnt), 32'd2);
    applyStimulus(8'h40, 1);
    i_sar_done = 1'b1;
    stepClk();
    checkOutput("t6 valid", 32'(avg_if.avg_valid), 32'd1);
    checkOutput("t6 data", 32'(avg_if.avg_data), 32'h40);
    i_sar_done = 1'b0;
    stepClk();

    // Randomised traffic against the model
    for (int it = 0; it < 400; it++) begin
      i_ena = ($urandom_range(0, 9) != 0);
      if (o_sample_cnt == 0 || $urandom_range(0, 3) == 0) i_log2_n = 3'($urandom_range(0, 3));
      avg_if.avg_ready = 1'($urandom_range(0, 1));
      i_clr_overrun = ($urandom_range(0, 7) == 0);
      applyStimulus(8'($urandom_range(0, 255)), int'($urandom_range(1, 3)));
      repeat ($urandom_range(0, 2)) stepClk();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
